// File: rtl/event_sync_hub.sv
// event_sync_hub
//
// Hardware rendezvous point between trigger sources and control FSMs that
// must block on them. Every event channel keeps a sticky "triggered" flag
// and a saturating trigger count. Each waiter slot arms on one event in one
// of two modes:
//   edge mode   : only a trigger that arrives after the arm edge matches.
//   sticky mode : an already-set flag, or a trigger at the arm edge, matches
//                 immediately.
// On a match the slot raises wake for one cycle. It also captures the
// timestamp of the matching edge.
//
// Ports
//   clk        : system clock, rising edge
//   rstn       : asynchronous active-low reset
//   trig       : [NUM_EVENTS]   single-cycle trigger per event
//   clr        : [NUM_EVENTS]   clear flag and count of an event
//   arm        : [NUM_WAITERS]  arm request per waiter slot
//   arm_sel    : [NUM_WAITERS*SEL_W] event select; slot w uses [w*SEL_W +: SEL_W]
//   arm_sticky : [NUM_WAITERS]  1 = sticky mode, 0 = edge mode
//   cancel     : [NUM_WAITERS]  abort a waiting slot
//   wake       : [NUM_WAITERS]  one-cycle wake pulse
//   wake_ts    : [NUM_WAITERS*TS_W] timestamp of the matching edge, held
//   waiting    : [NUM_WAITERS]  slot is blocked waiting for its event
//   triggered  : [NUM_EVENTS]   sticky triggered flags
//   trig_cnt   : [NUM_EVENTS*CNT_W] saturating trigger counts
//   now        : [TS_W]         free-running timestamp
module event_sync_hub #(
  parameter int NUM_EVENTS  = 4,
  parameter int NUM_WAITERS = 2,
  parameter int CNT_W       = 8,
  parameter int TS_W        = 16,
  localparam int SEL_W      = $clog2(NUM_EVENTS)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_EVENTS-1:0]        trig,
  input  logic [NUM_EVENTS-1:0]        clr,
  input  logic [NUM_WAITERS-1:0]       arm,
  input  logic [NUM_WAITERS*SEL_W-1:0] arm_sel,
  input  logic [NUM_WAITERS-1:0]       arm_sticky,
  input  logic [NUM_WAITERS-1:0]       cancel,
  output logic [NUM_WAITERS-1:0]       wake,
  output logic [NUM_WAITERS*TS_W-1:0]  wake_ts,
  output logic [NUM_WAITERS-1:0]       waiting,
  output logic [NUM_EVENTS-1:0]        triggered,
  output logic [NUM_EVENTS*CNT_W-1:0]  trig_cnt,
  output logic [TS_W-1:0]              now
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_WAKE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]       now_q;
  logic [NUM_EVENTS-1:0] flag_vec;

  // Free-running timestamp; wraps naturally at 2^TS_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      now_q <= '0;
    end else begin
      now_q <= now_q + 1'b1;
    end
  end

  assign now       = now_q;
  assign triggered = flag_vec;

  genvar gi;

  // Event channels: sticky flag plus saturating counter.
  generate
    for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_event
      logic             flag_q, flag_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (trig[gi]) begin
          flag_d = 1'b1;
          // A coincident clear restarts the count with this trigger.
          if (clr[gi]) begin
            cnt_d = CNT_W'(1);
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (clr[gi]) begin
          flag_d = 1'b0;
          cnt_d  = '0;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          flag_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          flag_q <= flag_d;
          cnt_q  <= cnt_d;
        end
      end

      assign flag_vec[gi]                  = flag_q;
      assign trig_cnt[gi*CNT_W +: CNT_W]   = cnt_q;
    end
  endgenerate

  // Waiter slots.
  generate
    for (gi = 0; gi < NUM_WAITERS; gi++) begin : g_waiter
      state_e           state_q;
      logic [SEL_W-1:0] sel_q;
      logic             sticky_q;
      logic [TS_W-1:0]  ts_q;
      logic             wake_q;
      logic             waiting_q;

      logic [SEL_W-1:0] arm_sel_w;
      logic             sel_ok;
      logic             arm_hit;
      logic             wait_hit;

      assign arm_sel_w = arm_sel[gi*SEL_W +: SEL_W];

      // When NUM_EVENTS is a power of two every select encoding is valid.
      if ((2 ** SEL_W) == NUM_EVENTS) begin : g_sel_full
        assign sel_ok = 1'b1;
      end else begin : g_sel_part
        assign sel_ok = (arm_sel_w < SEL_W'(NUM_EVENTS));
      end

      // Sticky arm matches an existing flag or a trigger on the arm edge.
      assign arm_hit  = sel_ok && arm_sticky[gi] &&
                        (flag_vec[arm_sel_w] || trig[arm_sel_w]);
      // While waiting, an edge match needs a fresh trigger; sticky also
      // accepts the flag, which can only return after a clear.
      assign wait_hit = trig[sel_q] || (sticky_q && flag_vec[sel_q]);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          state_q   <= S_IDLE;
          sel_q     <= '0;
          sticky_q  <= 1'b0;
          ts_q      <= '0;
          wake_q    <= 1'b0;
          waiting_q <= 1'b0;
        end else begin
          wake_q    <= 1'b0;
          waiting_q <= 1'b0;
          case (state_q)
            S_IDLE: begin
              if (arm[gi] && sel_ok) begin
                sel_q    <= arm_sel_w;
                sticky_q <= arm_sticky[gi];
                if (arm_hit) begin
                  state_q <= S_WAKE;
                  wake_q  <= 1'b1;
                  ts_q    <= now_q;
                end else begin
                  state_q   <= S_WAIT;
                  waiting_q <= 1'b1;
                end
              end
            end
            S_WAIT: begin
              // Cancel has priority over a coincident trigger.
              if (cancel[gi]) begin
                state_q <= S_IDLE;
              end else if (wait_hit) begin
                state_q <= S_WAKE;
                wake_q  <= 1'b1;
                ts_q    <= now_q;
              end else begin
                waiting_q <= 1'b1;
              end
            end
            S_WAKE: begin
              state_q <= S_IDLE;
            end
            default: begin
              state_q <= S_IDLE;
            end
          endcase
        end
      end

      assign wake[gi]                 = wake_q;
      assign waiting[gi]              = waiting_q;
      assign wake_ts[gi*TS_W +: TS_W] = ts_q;
    end
  endgenerate

endmodule

// File: tb/tb_event_sync_hub.sv
// Directed testbench for event_sync_hub. Instance "dut" uses the default
// parameters. Instance "dut_b" uses NUM_EVENTS=5, NUM_WAITERS=1, CNT_W=2
// and TS_W=4. With those values counter saturation, an out-of-range select
// and timestamp wrap can all be exercised within a few cycles.
module tb_event_sync_hub;

  localparam int NE = 4;
  localparam int NW = 2;
  localparam int CW = 8;
  localparam int TW = 16;
  localparam int SW = 2;

  localparam int BNE = 5;
  localparam int BSW = 3;
  localparam int BCW = 2;
  localparam int BTW = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic [NE-1:0]    trig, clr;
  logic [NW-1:0]    arm, arm_sticky, cancel;
  logic [NW*SW-1:0] arm_sel;
  logic [NW-1:0]    wake, waiting;
  logic [NW*TW-1:0] wake_ts;
  logic [NE-1:0]    triggered;
  logic [NE*CW-1:0] trig_cnt;
  logic [TW-1:0]    now;

  logic [BNE-1:0]     b_trig, b_clr;
  logic [0:0]         b_arm, b_arm_sticky, b_cancel;
  logic [BSW-1:0]     b_arm_sel;
  logic [0:0]         b_wake, b_waiting;
  logic [BTW-1:0]     b_wake_ts;
  logic [BNE-1:0]     b_triggered;
  logic [BNE*BCW-1:0] b_trig_cnt;
  logic [BTW-1:0]     b_now;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  event_sync_hub #(
    .NUM_EVENTS(NE), .NUM_WAITERS(NW), .CNT_W(CW), .TS_W(TW)
  ) dut (
    .clk(clk), .rstn(rstn), .trig(trig), .clr(clr), .arm(arm),
    .arm_sel(arm_sel), .arm_sticky(arm_sticky), .cancel(cancel),
    .wake(wake), .wake_ts(wake_ts), .waiting(waiting),
    .triggered(triggered), .trig_cnt(trig_cnt), .now(now)
  );

  event_sync_hub #(
    .NUM_EVENTS(BNE), .NUM_WAITERS(1), .CNT_W(BCW), .TS_W(BTW)
  ) dut_b (
    .clk(clk), .rstn(rstn), .trig(b_trig), .clr(b_clr), .arm(b_arm),
    .arm_sel(b_arm_sel), .arm_sticky(b_arm_sticky), .cancel(b_cancel),
    .wake(b_wake), .wake_ts(b_wake_ts), .waiting(b_waiting),
    .triggered(b_triggered), .trig_cnt(b_trig_cnt), .now(b_now)
  );

  // Inputs change 1 ns after the rising edge. Outputs are sampled at the
  // same point. When step returns, now == cyc.
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs;
    trig = '0; clr = '0; arm = '0; arm_sel = '0; arm_sticky = '0; cancel = '0;
    b_trig = '0; b_clr = '0; b_arm = '0; b_arm_sel = '0; b_arm_sticky = '0;
    b_cancel = '0;
  endtask

  // Release reset at a falling edge so the next rising edge gives now = 1.
  task automatic do_reset;
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({wake, waiting, triggered, trig_cnt, now, wake_ts} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %0h want 0", {wake, waiting, triggered, trig_cnt, now, wake_ts});
    end
    @(negedge clk);
    rstn = 1'b1;
    cyc = 0;
    for (int c = 0; c < 5; c++) begin
      arm = (c == 2) ? 2'b01 : 2'b00;
      arm_sel = 4'b0001;
      trig = (c == 3) ? 4'b0100 : 4'b0000;
      step();
    end
    clear_inputs();
    n_cmp++;
    if (waiting !== 2'b01) begin n_bad++; $display("FAIL pre_reset_waiting: got %b want 01", waiting); end
    n_cmp++;
    if (trig_cnt !== 32'h0001_0000) begin n_bad++; $display("FAIL pre_reset_cnt: got %h want 00010000", trig_cnt); end
    n_cmp++;
    if (now !== 16'd5) begin n_bad++; $display("FAIL pre_reset_now: got %0d want 5", now); end
    // Assert reset between clock edges; outputs must clear without an edge.
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (waiting !== 2'b00) begin n_bad++; $display("FAIL async_waiting: got %b want 00", waiting); end
    n_cmp++;
    if (triggered !== 4'b0000) begin n_bad++; $display("FAIL async_triggered: got %b want 0000", triggered); end
    n_cmp++;
    if (trig_cnt !== '0) begin n_bad++; $display("FAIL async_cnt: got %h want 0", trig_cnt); end
    n_cmp++;
    if ({now, wake} !== '0) begin n_bad++; $display("FAIL async_now_wake: got now=%0d wake=%b want 0", now, wake); end
    $display("test_reset: async reset at cycle 5 done");
  endtask

  task automatic test_edge_arm;
    int nwake = 0;
    int wcyc = -1;
    logic [TW-1:0] wts = '0;
    do_reset();
    for (int c = 0; c <= 105; c++) begin
      trig = (c == 20 || c == 50 || c == 100) ? 4'b0001 : 4'b0000;
      arm = (c == 25) ? 2'b01 : 2'b00;
      arm_sel = '0;
      arm_sticky = '0;
      step();
      if (wake[0]) begin nwake++; wcyc = cyc; wts = wake_ts[15:0]; end
    end
    clear_inputs();
    n_cmp++;
    if (nwake !== 1) begin n_bad++; $display("FAIL edge_wake_count: got %0d want 1", nwake); end
    n_cmp++;
    if (wcyc !== 51) begin n_bad++; $display("FAIL edge_wake_cycle: got %0d want 51", wcyc); end
    n_cmp++;
    if (wts !== 16'd50) begin n_bad++; $display("FAIL edge_wake_ts: got %0d want 50", wts); end
    n_cmp++;
    if (trig_cnt[7:0] !== 8'd3) begin n_bad++; $display("FAIL edge_trig_cnt: got %0d want 3", trig_cnt[7:0]); end
    n_cmp++;
    if (triggered !== 4'b0001) begin n_bad++; $display("FAIL edge_triggered: got %b want 0001", triggered); end
    n_cmp++;
    if (now !== 16'd106) begin n_bad++; $display("FAIL edge_now: got %0d want 106", now); end
    $display("test_edge_arm: wakes=%0d cycle=%0d ts=%0d", nwake, wcyc, wts);
  endtask

  task automatic test_sticky;
    int nwake = 0;
    int wcyc = -1;
    do_reset();
    for (int c = 0; c <= 125; c++) begin
      trig = (c == 110) ? 4'b1000 : 4'b0000;
      arm = (c == 120) ? 2'b10 : 2'b00;
      arm_sel = 4'b1100;
      arm_sticky = 2'b10;
      step();
      if (wake[1]) begin nwake++; wcyc = cyc; end
    end
    clear_inputs();
    n_cmp++;
    if (nwake !== 1 || wcyc !== 121) begin
      n_bad++; $display("FAIL sticky_wake: got count=%0d cycle=%0d want count=1 cycle=121", nwake, wcyc);
    end
    n_cmp++;
    if (waiting !== 2'b00) begin n_bad++; $display("FAIL sticky_waiting: got %b want 00", waiting); end
    $display("test_sticky: sticky wakes=%0d cycle=%0d", nwake, wcyc);

    nwake = 0;
    do_reset();
    for (int c = 0; c <= 130; c++) begin
      trig = (c == 110) ? 4'b1000 : 4'b0000;
      arm = (c == 120) ? 2'b10 : 2'b00;
      arm_sel = 4'b1100;
      arm_sticky = 2'b00;
      step();
      if (wake != 2'b00) nwake++;
    end
    clear_inputs();
    n_cmp++;
    if (nwake !== 0) begin n_bad++; $display("FAIL edge_after_flag_wake: got %0d wakes want 0", nwake); end
    n_cmp++;
    if (waiting !== 2'b10) begin n_bad++; $display("FAIL edge_after_flag_waiting: got %b want 10", waiting); end
    $display("test_sticky: edge-mode wakes=%0d waiting=%b", nwake, waiting);
  endtask

  task automatic test_cancel;
    int nwake1 = 0;
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      arm = (c == 30) ? 2'b11 : 2'b00;
      arm_sel = 4'b1010;
      arm_sticky = 2'b00;
      trig = (c == 40) ? 4'b0100 : 4'b0000;
      cancel = (c == 40) ? 2'b10 : 2'b00;
      step();
      if (wake[1]) nwake1++;
      if (cyc == 35) begin
        n_cmp++;
        if (waiting !== 2'b11) begin n_bad++; $display("FAIL cancel_both_waiting: got %b want 11", waiting); end
      end
      if (cyc == 41) begin
        n_cmp++;
        if (wake !== 2'b01) begin n_bad++; $display("FAIL cancel_wake: got %b want 01", wake); end
        n_cmp++;
        if (waiting !== 2'b00) begin n_bad++; $display("FAIL cancel_waiting: got %b want 00", waiting); end
        n_cmp++;
        if (wake_ts[15:0] !== 16'd40) begin n_bad++; $display("FAIL cancel_ts0: got %0d want 40", wake_ts[15:0]); end
      end
    end
    clear_inputs();
    n_cmp++;
    if (nwake1 !== 0) begin n_bad++; $display("FAIL cancel_slot1_wakes: got %0d want 0", nwake1); end
    $display("test_cancel: slot1 wakes=%0d", nwake1);
  endtask

  task automatic test_same_cycle_arm;
    int nwake = 0;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      arm = (c == 10) ? 2'b01 : 2'b00;
      arm_sel = 4'b0001;
      arm_sticky = 2'b00;
      trig = (c == 10 || c == 15) ? 4'b0010 : 4'b0000;
      step();
      if (wake[0]) nwake++;
      if (cyc == 11) begin
        n_cmp++;
        if ({wake, waiting} !== 4'b0001) begin
          n_bad++; $display("FAIL same_cycle_arm: got wake=%b waiting=%b want 00/01", wake, waiting);
        end
      end
      if (cyc == 16) begin
        n_cmp++;
        if (wake[0] !== 1'b1 || wake_ts[15:0] !== 16'd15) begin
          n_bad++; $display("FAIL same_cycle_next_trig: got wake=%b ts=%0d want 1/15", wake[0], wake_ts[15:0]);
        end
      end
    end
    clear_inputs();
    n_cmp++;
    if (nwake !== 1) begin n_bad++; $display("FAIL same_cycle_wakes: got %0d want 1", nwake); end
    $display("test_same_cycle_arm: wakes=%0d", nwake);
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      clear_inputs();
      if (c == 5) begin arm = 2'b11; arm_sticky = 2'b11; end
      if (c == 8) trig = 4'b0001;
      if (c == 9) begin arm = 2'b01; arm_sticky = 2'b00; end
      if (c == 10) begin arm = 2'b01; arm_sticky = 2'b01; end
      step();
      if (cyc == 6) begin
        n_cmp++;
        if (waiting !== 2'b11) begin n_bad++; $display("FAIL b2b_sticky_wait: got %b want 11", waiting); end
      end
      if (cyc == 9) begin
        n_cmp++;
        if (wake !== 2'b11) begin n_bad++; $display("FAIL b2b_shared_wake: got %b want 11", wake); end
        n_cmp++;
        if (wake_ts !== {16'd8, 16'd8}) begin n_bad++; $display("FAIL b2b_shared_ts: got %h want 00080008", wake_ts); end
      end
      if (cyc == 10) begin
        n_cmp++;
        if ({wake, waiting} !== 4'b0000) begin
          n_bad++; $display("FAIL b2b_arm_in_wake: got wake=%b waiting=%b want 00/00", wake, waiting);
        end
      end
      if (cyc == 11) begin
        n_cmp++;
        if (wake !== 2'b01) begin n_bad++; $display("FAIL b2b_rearm_wake: got %b want 01", wake); end
        n_cmp++;
        if (triggered[0] !== 1'b1 || wake_ts[31:16] !== 16'd8) begin
          n_bad++; $display("FAIL b2b_flag_ts_held: got flag=%b ts1=%0d want 1/8", triggered[0], wake_ts[31:16]);
        end
      end
    end
    clear_inputs();
    $display("test_back_to_back: done at cycle %0d", cyc);
  endtask

  task automatic test_saturate;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b_trig = 5'b00010;
      step();
      if (i == 1) begin
        n_cmp++;
        if (b_trig_cnt[3:2] !== 2'd2) begin n_bad++; $display("FAIL sat_cnt_two: got %0d want 2", b_trig_cnt[3:2]); end
      end
    end
    b_trig = '0;
    n_cmp++;
    if (b_trig_cnt !== 10'b00_00_00_11_00) begin n_bad++; $display("FAIL sat_cnt: got %b want 0000001100", b_trig_cnt); end
    b_trig = 5'b00010;
    b_clr = 5'b00010;
    step();
    b_trig = '0;
    b_clr = '0;
    n_cmp++;
    if (b_trig_cnt[3:2] !== 2'd1 || b_triggered !== 5'b00010) begin
      n_bad++; $display("FAIL trig_clr_same: got cnt=%0d flag=%b want 1/00010", b_trig_cnt[3:2], b_triggered);
    end
    b_clr = 5'b00010;
    step();
    b_clr = '0;
    n_cmp++;
    if (b_trig_cnt !== '0 || b_triggered !== '0) begin
      n_bad++; $display("FAIL clr_alone: got cnt=%b flag=%b want 0/0", b_trig_cnt, b_triggered);
    end
    $display("test_saturate: cnt=%b flags=%b", b_trig_cnt, b_triggered);
  endtask

  task automatic test_bad_sel_wrap;
    do_reset();
    b_arm = 1'b1;
    b_arm_sel = 3'd5;
    step();
    b_arm = 1'b0;
    n_cmp++;
    if (b_waiting !== 1'b0) begin n_bad++; $display("FAIL bad_sel_ignored: got waiting=%b want 0", b_waiting); end
    b_arm = 1'b1;
    b_arm_sel = 3'd4;
    step();
    b_arm = 1'b0;
    n_cmp++;
    if (b_waiting !== 1'b1) begin n_bad++; $display("FAIL top_sel_accepted: got waiting=%b want 1", b_waiting); end
    while (cyc < 15) step();
    n_cmp++;
    if (b_now !== 4'd15) begin n_bad++; $display("FAIL now_max: got %0d want 15", b_now); end
    step();
    n_cmp++;
    if (b_now !== 4'd0) begin n_bad++; $display("FAIL now_wrap: got %0d want 0", b_now); end
    $display("test_bad_sel_wrap: now=%0d waiting=%b", b_now, b_waiting);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within 1 ms");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_edge_arm();
    test_sticky();
    test_cancel();
    test_same_cycle_arm();
    test_back_to_back();
    test_saturate();
    test_bad_sel_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
